// File: rtl/key_scan_arbiter.sv
// Scans raw key inputs through one shared debounce timer, keeps the debounced
// key vector and picks the sounding note with last-pressed priority.
module key_scan_arbiter #(
    parameter int NUM_KEYS  = 8,
    parameter int DB_CYCLES = 250000,
    parameter int NOTE_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic [NOTE_W-1:0]   note_sel,
    output logic                note_valid,
    output logic                note_start
);
    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DB_CYCLES - 1);
    localparam logic [NOTE_W-1:0] IDX_LAST = NOTE_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync_r;
    state_t              state_r;
    logic [NOTE_W-1:0]   idx_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                key_diff_s;
    logic [NOTE_W-1:0]   idx_next_s;
    logic [NUM_KEYS-1:0] next_stable_s;
    logic [NOTE_W-1:0]   lowest_held_s;

    // Two-flop synchronizer for the asynchronous key levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync_r  <= '0;
        end else begin
            sync1_r <= keys_raw;
            sync_r  <= sync1_r;
        end
    end

    // Scan bookkeeping: current-key difference, wrapped next index and the
    // key vector as it would look after committing the current key
    always_comb begin
        key_diff_s    = (sync_r[idx_r] != keys_stable[idx_r]);
        if (idx_r == IDX_LAST) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + NOTE_W'(1);
        end
        next_stable_s        = keys_stable;
        next_stable_s[idx_r] = sync_r[idx_r];
    end

    // Legato fallback target: lowest-index key still held after the commit
    always_comb begin
        lowest_held_s = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (next_stable_s[k]) begin
                lowest_held_s = NOTE_W'(k);
            end else begin
                lowest_held_s = lowest_held_s;
            end
        end
    end

    // Scan/debounce FSM with registered arbiter outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_SCAN;
            idx_r       <= '0;
            cnt_r       <= '0;
            keys_stable <= '0;
            note_sel    <= '0;
            note_valid  <= 1'b0;
            note_start  <= 1'b0;
        end else begin
            note_start <= 1'b0;
            case (state_r)
                ST_SCAN: begin
                    if (key_diff_s) begin
                        state_r <= ST_COUNT;
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        idx_r <= idx_next_s;
                    end
                end
                ST_COUNT: begin
                    if (!key_diff_s) begin
                        state_r <= ST_SCAN;
                        idx_r   <= idx_next_s;
                    end else if (cnt_r == '0) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    // A level that reverted in the last cycle commits nothing
                    if (key_diff_s) begin
                        keys_stable <= next_stable_s;
                        note_valid  <= |next_stable_s;
                        if (sync_r[idx_r]) begin
                            note_sel   <= idx_r;
                            note_start <= 1'b1;
                        end else if ((idx_r == note_sel) && (|next_stable_s)) begin
                            note_sel <= lowest_held_s;
                        end else begin
                            note_sel <= note_sel;
                        end
                    end else begin
                        keys_stable <= keys_stable;
                    end
                    idx_r   <= idx_next_s;
                    state_r <= ST_SCAN;
                end
                default: begin
                    state_r <= ST_SCAN;
                end
            endcase
        end
    end
endmodule
